// File: rtl/vx_cmt_csr_ctrl.sv
// vx_cmt_csr_ctrl: commit-lane reduction and 64-bit instret counter (CMT_FPU_SRC_EN adds FPU lane 5)
module vx_cmt_csr_ctrl #(
  parameter int NUM_THREADS = 4,
`ifdef CMT_FPU_SRC_EN
  parameter int NUM_SRCS    = 6,
`else
  parameter int NUM_SRCS    = 5,
`endif
  parameter int SIZE_W      = $clog2(NUM_SRCS*NUM_THREADS+1)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_SRCS-1:0]             src_valid,
  input  logic [NUM_SRCS*NUM_THREADS-1:0] src_tmask,
  input  logic                            inhibit_ir,
  input  logic                            csr_wr_valid,
  input  logic                            csr_wr_hi,
  input  logic [31:0]                     csr_wr_data,
  output logic                            cmt_valid,
  output logic [SIZE_W-1:0]               commit_size,
  output logic [63:0]                     instret
);
  logic [SIZE_W-1:0] sum;
  logic [63:0]       base;
  logic [63:0]       delta;
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_SRCS; i++)
      for (int j = 0; j < NUM_THREADS; j++)
        sum = sum + SIZE_W'(src_valid[i] & src_tmask[i*NUM_THREADS+j]);
  end
  // the write replaces one half without carry; the commit delta is then added across all 64 bits
  assign base  = csr_wr_valid ? (csr_wr_hi ? {csr_wr_data, instret[31:0]} : {instret[63:32], csr_wr_data}) : instret;
  assign delta = (cmt_valid && !inhibit_ir) ? 64'(commit_size) : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmt_valid   <= 1'b0;
      commit_size <= '0;
      instret     <= '0;
    end else begin
      cmt_valid   <= |src_valid;
      commit_size <= sum;
      instret     <= base + delta;
    end
  end
endmodule

// File: tb/tb_vx_cmt_csr_ctrl.sv
// tb_vx_cmt_csr_ctrl: directed scoreboard bench for vx_cmt_csr_ctrl (default build, 5 lanes x 4 threads)
module tb_vx_cmt_csr_ctrl;
  typedef struct { logic v; logic [4:0] sz; } s1_t;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  src_valid;
  logic [19:0] src_tmask;
  logic        inhibit_ir, csr_wr_valid, csr_wr_hi;
  logic [31:0] csr_wr_data;
  logic        cmt_valid;
  logic [4:0]  commit_size;
  logic [63:0] instret;
  s1_t         exp_q[$];
  logic        s1_v;
  logic [4:0]  s1_sz;
  logic [63:0] exp_instret;
  int          errors = 0;
  int          checks = 0;

  vx_cmt_csr_ctrl dut (
    .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_tmask(src_tmask),
    .inhibit_ir(inhibit_ir), .csr_wr_valid(csr_wr_valid), .csr_wr_hi(csr_wr_hi),
    .csr_wr_data(csr_wr_data), .cmt_valid(cmt_valid), .commit_size(commit_size), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] fsum(input logic [4:0] v, input logic [19:0] m);
    int s = 0;
    for (int i = 0; i < 5; i++) if (v[i]) s += $countones(m[i*4 +: 4]);
    return 5'(s);
  endfunction

  task automatic step(input logic [4:0] v, input logic [19:0] m, input logic inh,
                      input logic wr, input logic hi, input logic [31:0] d);
    s1_t e;
    logic [63:0] b;
    src_valid = v; src_tmask = m; inhibit_ir = inh;
    csr_wr_valid = wr; csr_wr_hi = hi; csr_wr_data = d;
    exp_q.push_back('{v != 0, (v != 0) ? fsum(v, m) : 5'd0});
    b = exp_instret;
    if (wr) begin
      if (hi) b[63:32] = d;
      else b[31:0] = d;
    end
    exp_instret = b + ((s1_v && !inh) ? 64'(s1_sz) : 64'd0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    s1_v = e.v; s1_sz = e.sz;
    chk("cmt_valid", 64'(cmt_valid), 64'(e.v));
    chk("commit_size", 64'(commit_size), 64'(e.sz));
    chk("instret", instret, exp_instret);
  endtask

  task automatic idle(input logic inh = 1'b0);
    step(5'd0, 20'd0, inh, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic wr64(input logic [63:0] val);
    step(5'd0, 20'd0, 1'b0, 1'b1, 1'b1, val[63:32]);
    step(5'd0, 20'd0, 1'b0, 1'b1, 1'b0, val[31:0]);
  endtask

  initial begin
    reset_n = 1'b0; src_valid = '0; src_tmask = '0; inhibit_ir = 1'b0;
    csr_wr_valid = 1'b0; csr_wr_hi = 1'b0; csr_wr_data = '0;
    s1_v = 1'b0; s1_sz = '0; exp_instret = '0;
    #1;
    chk("rst_cmt_valid", 64'(cmt_valid), 64'd0);
    chk("rst_commit_size", 64'(commit_size), 64'd0);
    chk("rst_instret", instret, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    idle();
    // ALU F, LSU 3, CSR F (invalid), MUL 1, GPU 0
    step(5'b01011, {4'h0, 4'h1, 4'hF, 4'h3, 4'hF}, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("reduce_size7", 64'(commit_size), 64'd7);
    idle();
    chk("reduce_instret7", instret, 64'd7);
    step(5'b00001, 20'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("zero_mask_valid", 64'(cmt_valid), 64'd1);
    idle();
    // same-cycle low write and commit of 4
    step(5'd0, 20'd0, 1'b0, 1'b1, 1'b1, 32'd5);
    step(5'd0, 20'd0, 1'b0, 1'b1, 1'b0, 32'd100);
    step(5'b00001, 20'h0000F, 1'b0, 1'b0, 1'b0, 32'd0);
    step(5'd0, 20'd0, 1'b0, 1'b1, 1'b0, 32'h10);
    chk("wr_commit", instret, 64'h0000_0005_0000_0014);
    wr64(64'h0000_0000_FFFF_FFFE);
    step(5'b00001, 20'h00007, 1'b0, 1'b0, 1'b0, 32'd0);
    idle();
    chk("carry", instret, 64'h0000_0001_0000_0001);
    wr64(64'hFFFF_FFFF_FFFF_FFFF);
    step(5'b00010, 20'h00070, 1'b0, 1'b0, 1'b0, 32'd0);
    idle();
    chk("wrap", instret, 64'd2);
    for (int i = 0; i < 10; i++) step(5'b00001, 20'h0000F, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("inhibit_hold", instret, 64'd2);
    step(5'b00001, 20'h0000F, 1'b1, 1'b1, 1'b1, 32'd9);
    chk("inhibit_wr", instret, 64'h0000_0009_0000_0002);
    for (int i = 0; i < 3; i++) step(5'b00001, 20'h0000F, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("inhibit_resume", instret, 64'h0000_0009_0000_000E);
    step(5'b11111, 20'hFFFFF, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("all_lanes20", 64'(commit_size), 64'd20);
    idle();
    for (int i = 0; i < 20; i++)
      step(5'($urandom), 20'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom), $urandom);
    idle();
    wr64(64'h0000_0000_0000_1234);
    step(5'b11111, 20'hFFFFF, 1'b0, 1'b0, 1'b0, 32'd0);
    #1; reset_n = 1'b0; #1;
    chk("mid_rst_cmt_valid", 64'(cmt_valid), 64'd0);
    chk("mid_rst_commit_size", 64'(commit_size), 64'd0);
    chk("mid_rst_instret", instret, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete(); s1_v = 1'b0; s1_sz = '0; exp_instret = '0;
    idle();
    idle();
    chk("post_rst_instret", instret, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vx_cmt_csr_ctrl.md
# vx_cmt_csr_ctrl

Commit-to-CSR controller for one Vortex core. It collects per-cycle commit events from the execute-unit commit lanes and reduces each lane's thread mask to a retired-thread count. It drives the registered `valid` / `commit_size` pair consumed by the CSR unit. It also owns the 64-bit retired-instruction counter (`minstret`/`minstreth`), including CSR write-back and count inhibit.

## Interface
Parameters:
- `NUM_THREADS`, 4: threads per warp.
- `NUM_SRCS`, 5 (6 with `CMT_FPU_SRC_EN`): commit lanes, ordered ALU, LSU, CSR, MUL, GPU[, FPU]. Derived from the macro; never overridden.
- `SIZE_W`, `$clog2(NUM_SRCS*NUM_THREADS+1)`: width of `commit_size`.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `src_valid`  in  `NUM_SRCS`  lane i commits this cycle.
- `src_tmask`  in  `NUM_SRCS*NUM_THREADS`  thread mask of lane i, at slice [i*NUM_THREADS +: NUM_THREADS].
- `inhibit_ir`  in  1  `mcountinhibit.IR`; freezes the counter.
- `csr_wr_valid`  in  1  CSR write to the instret counter.
- `csr_wr_hi`  in  1  write targets bits [63:32]; 0 targets bits [31:0].
- `csr_wr_data`  in  32  write data.
- `cmt_valid`  out  1  registered commit strobe to the CSR unit.
- `commit_size`  out  `SIZE_W`  registered retired-thread count.
- `instret`  out  64  current counter value.

## Operation
- The block always accepts lane inputs; there is no back-pressure. A lane counts only when `src_valid[i]=1`; its mask is ignored otherwise.
- Stage 1 (reduce): `sum = Σ popcount(src_tmask[i])` over lanes with `src_valid[i]=1`, zero-extended to `SIZE_W`.
  - Registered as `cmt_valid <= |src_valid` and `commit_size <= (|src_valid) ? sum : 0`.
  - A valid lane with an all-zero mask still raises `cmt_valid`, with its size contribution 0.
- Stage 2 (count): each cycle the counter updates from the stage-1 registers:
  - `base` = `instret`, with the addressed 32-bit half replaced by `csr_wr_data` when `csr_wr_valid=1`.
  - `delta` = (`cmt_valid && !inhibit_ir`) ? `commit_size` : 0.
  - `instret <= base + delta`, modulo 2^64.
- Write plus commit in the same cycle: the write lands first, then the delta is added. No commit is lost.
- A low-half write does not carry into the high half. Any carry from adding `delta` does propagate into the high half.
- `inhibit_ir=1` blocks counting only; `cmt_valid` and `commit_size` still drive the CSR unit. CSR writes are honoured while inhibited.

## Timing
- Reset (`reset_n=0`, asynchronous assert, synchronous-to-`clk` deassert by upstream): `cmt_valid=0`, `commit_size=0`, `instret=0`. Outputs go to these values immediately on assertion, independent of `clk`.
- Reset mid-operation: in-flight stage-1 data is discarded and never counted.
- Latency:
  - Lane inputs at edge T appear on `cmt_valid`/`commit_size` after edge T+1.
  - They are reflected in `instret` after edge T+2.
  - A CSR write at edge T is visible on `instret` after edge T+1.
- `inhibit_ir` is sampled in the stage-2 cycle, i.e. the cycle in which `cmt_valid` is high.
- Full throughput: one commit event per cycle. Back-to-back cycles are counted independently; there is no coalescing.
- Wrap-around: `0xFFFF_FFFF_FFFF_FFFF + 3 = 0x0000_0000_0000_0002`, with no flag.

## Configuration
- `CMT_FPU_SRC_EN` defined:
  - `NUM_SRCS=6`, lane 5 = FPU.
  - `SIZE_W=$clog2(6*NUM_THREADS+1)`, which is 5 for 4 threads.
- Undefined:
  - `NUM_SRCS=5`, `SIZE_W=$clog2(5*NUM_THREADS+1)`, which is 5 for 4 threads and 6 for 8 threads.
  - No FPU lane ports exist.

## Test plan
- Reset: assert `reset_n=0` mid-stream with `instret=0x1234` → all outputs are 0 immediately. After release plus an idle cycle, `instret` is still 0.
- Reduction: NUM_THREADS=4; ALU mask 0xF, LSU 0x3, MUL 0x1, all valid; CSR lane not valid with mask 0xF → next cycle `cmt_valid=1`, `commit_size=7`. Two cycles later `instret=7`.
- Same-cycle write and commit: `instret=100`; write lo=`0x10` in the cycle `commit_size=4` is in stage 2 → `instret=0x14`, and the high half is unchanged.
- Carry and wrap:
  - Preload `0x0000_0000_FFFF_FFFE`, commit 3 → `0x0000_0001_0000_0001`.
  - Preload all-ones, commit 3 → `2`.
- Inhibit: `inhibit_ir=1`, 10 cycles of `commit_size=4` → `cmt_valid` pulses each cycle and `instret` is unchanged. Deassert → the count resumes +4 per cycle.
- Config: with `CMT_FPU_SRC_EN`, all 6 lanes valid with mask 0xF → `commit_size=24`. Without it, 5 lanes → `commit_size=20`.
